// File: rtl/reg_master_pkg.sv
// ---------------------------------------------------------------------------
// reg_master_pkg
// Shared definitions for the register-bus initiator and its neighbours:
//   - REG_DATA_WIDTH : register data width (tracks `CPCI_NF2_DATA_WIDTH)
//   - TIMEOUT_DATA   : read-data pattern returned for abandoned accesses;
//                      the unused-address responders return the same value
//   - state_t        : initiator FSM encoding
// ---------------------------------------------------------------------------
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

package reg_master_pkg;

    localparam int REG_DATA_WIDTH = `CPCI_NF2_DATA_WIDTH;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/reg_master_if.sv
// ---------------------------------------------------------------------------
// reg_master_if
// Bundles the three buses around the register initiator:
//   command port  : cmd_valid/cmd_ready, cmd_rd_wr_L, cmd_addr, cmd_wr_data
//   response port : rsp_valid/rsp_ready, rsp_data, rsp_timeout
//   register bus  : reg_req/reg_ack, reg_rd_wr_L, reg_addr, reg_wr_data,
//                   rd_data_in
// modport master : the initiator's view (reg_master)
// modport slave  : the environment's view (host bridge + register slaves)
// ---------------------------------------------------------------------------
interface reg_master_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = reg_master_pkg::REG_DATA_WIDTH
) ();

    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_rd_wr_L;
    logic [REG_ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0]     cmd_wr_data;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_WIDTH-1:0]     rsp_data;
    logic                      rsp_timeout;

    logic                      reg_req;
    logic                      reg_ack;
    logic                      reg_rd_wr_L;
    logic [REG_ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0]     reg_wr_data;
    logic [DATA_WIDTH-1:0]     rd_data_in;

    modport master (
        input  cmd_valid, cmd_rd_wr_L, cmd_addr, cmd_wr_data,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_timeout,
        input  rsp_ready,
        output reg_req, reg_rd_wr_L, reg_addr, reg_wr_data,
        input  reg_ack, rd_data_in
    );

    modport slave (
        output cmd_valid, cmd_rd_wr_L, cmd_addr, cmd_wr_data,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_timeout,
        output rsp_ready,
        input  reg_req, reg_rd_wr_L, reg_addr, reg_wr_data,
        output reg_ack, rd_data_in
    );

endinterface

// File: rtl/reg_timeout_ctr.sv
// ---------------------------------------------------------------------------
// reg_timeout_ctr
// Clearable up-counter with a terminal-count flag.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (has priority over en)
//   en         : count up by one
//   tc         : high while the count equals TERMINAL
// ---------------------------------------------------------------------------
module reg_timeout_ctr #(
    parameter int WIDTH    = 8,
    parameter int TERMINAL = 254
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tc = (count_reg == WIDTH'(TERMINAL));

endmodule

// File: rtl/reg_master.sv
// ---------------------------------------------------------------------------
// reg_master
// Single-outstanding register-bus initiator. Takes one read/write command
// from the host port, drives reg_req until reg_ack or a timeout, and returns
// read data (0 for writes, TIMEOUT_DATA on timeout) on the response port.
//   clk, reset    : clock, asynchronous active-low reset
//   bus           : reg_master_if.master (command, response, register bus)
//   timeout_count : saturating count of accesses abandoned by timeout
// ---------------------------------------------------------------------------
module reg_master
    import reg_master_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = REG_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_CNT_WIDTH   = 8
) (
    input  logic                clk,
    input  logic                reset,
    reg_master_if.master        bus,
    output logic [15:0]         timeout_count
);

    state_t state_reg, state_next;

    logic                      reg_rd_wr_L_reg;
    logic [REG_ADDR_WIDTH-1:0] reg_addr_reg;
    logic [DATA_WIDTH-1:0]     reg_wr_data_reg;
    logic [DATA_WIDTH-1:0]     rsp_data_reg;
    logic                      rsp_timeout_reg;
    logic [15:0]               timeout_count_reg;

    logic cmd_ready_c, reg_req_c, rsp_valid_c;
    logic to_tc;
    logic cmd_fire, ack_take, to_fire, rsp_fire;

    // Ack has priority over the terminal count in the same cycle.
    assign cmd_fire = (state_reg == ST_IDLE) && bus.cmd_valid;
    assign ack_take = (state_reg == ST_REQ)  && bus.reg_ack;
    assign to_fire  = (state_reg == ST_REQ)  && !bus.reg_ack && to_tc;
    assign rsp_fire = (state_reg == ST_RESP) && bus.rsp_ready;

    // Counter sits at zero throughout IDLE, so it starts each access from 0;
    // it stops at the terminal value rather than wrapping.
    reg_timeout_ctr #(
        .WIDTH    (TO_CNT_WIDTH),
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_timeout_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (state_reg == ST_IDLE),
        .en    ((state_reg == ST_REQ) && !bus.reg_ack && !to_tc),
        .tc    (to_tc)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (cmd_fire)             state_next = ST_REQ;
            ST_REQ:  if (ack_take || to_fire)  state_next = ST_RESP;
            ST_RESP: if (rsp_fire)             state_next = ST_IDLE;
            default:                           state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state. Because reg_req and rsp_valid come straight
    // from the state register they fall as soon as reset is asserted;
    // cmd_ready is additionally gated by reset so it stays low during reset.
    always_comb begin
        cmd_ready_c = 1'b0;
        reg_req_c   = 1'b0;
        rsp_valid_c = 1'b0;
        case (state_reg)
            ST_IDLE: cmd_ready_c = reset;
            ST_REQ:  reg_req_c   = 1'b1;
            ST_RESP: rsp_valid_c = 1'b1;
            default: ;
        endcase
    end

    // Datapath: command capture, response capture, timeout statistics
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_rd_wr_L_reg   <= 1'b1;
            reg_addr_reg      <= '0;
            reg_wr_data_reg   <= '0;
            rsp_data_reg      <= '0;
            rsp_timeout_reg   <= 1'b0;
            timeout_count_reg <= '0;
        end else begin
            if (cmd_fire) begin
                reg_rd_wr_L_reg <= bus.cmd_rd_wr_L;
                reg_addr_reg    <= bus.cmd_addr;
                reg_wr_data_reg <= bus.cmd_wr_data;
            end
            if (ack_take) begin
                rsp_data_reg    <= reg_rd_wr_L_reg ? bus.rd_data_in : '0;
                rsp_timeout_reg <= 1'b0;
            end else if (to_fire) begin
                rsp_data_reg    <= DATA_WIDTH'(TIMEOUT_DATA);
                rsp_timeout_reg <= 1'b1;
                if (timeout_count_reg != 16'hFFFF) begin
                    timeout_count_reg <= timeout_count_reg + 16'd1;
                end
            end
            if (rsp_fire) begin
                rsp_timeout_reg <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready   = cmd_ready_c;
    assign bus.reg_req     = reg_req_c;
    assign bus.rsp_valid   = rsp_valid_c;
    assign bus.rsp_data    = rsp_data_reg;
    assign bus.rsp_timeout = rsp_timeout_reg;
    assign bus.reg_rd_wr_L = reg_rd_wr_L_reg;
    assign bus.reg_addr    = reg_addr_reg;
    assign bus.reg_wr_data = reg_wr_data_reg;
    assign timeout_count   = timeout_count_reg;

endmodule
